// File: rtl/seq_resource_arbiter_pkg.sv
// Shared constants for the sequenced resource arbiter: state encodings, driver
// bundle bit positions and the default per-phase masks for the sensor phases.
package seq_resource_arbiter_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StErr  = 2'd3;

  localparam int unsigned ROW_DATA  = 4;
  localparam int unsigned ROW_WRITE = 3;
  localparam int unsigned COL_DATA  = 2;
  localparam int unsigned COL_WRITE = 1;
  localparam int unsigned KEY_WREN  = 0;

  localparam int unsigned PH_RESET   = 0;
  localparam int unsigned PH_SCAN    = 1;
  localparam int unsigned PH_PROCESS = 2;
  localparam int unsigned PH_CONF    = 3;

  // Row drivers stay enabled except while processing; processing holds the
  // column reset and forces the RAM read port.
  localparam logic [3:0] DEF_ROW_ENA_MASK = 4'b1011;
  localparam logic [3:0] DEF_COL_RST_MASK = 4'b0100;
  localparam logic [3:0] DEF_RAM_RD_MASK  = 4'b0100;

endpackage

// File: rtl/seq_next_phase.sv
// Combinational priority search: lowest set mask bit at or above a start index.
module seq_next_phase #(
  parameter int unsigned N_PH = 4,
  parameter int unsigned PH_W = 2
) (
  input  logic [N_PH-1:0] mask,
  input  logic [PH_W:0]   start,
  output logic [PH_W-1:0] idx,
  output logic            found
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Descending scan so the lowest qualifying bit is the last one written.
    for (int k = N_PH - 1; k >= 0; k--) begin
      if (mask[k] && ((PH_W + 1)'(k) >= start)) begin
        found = 1'b1;
        idx   = PH_W'(k);
      end
    end
  end

endmodule

// File: rtl/seq_resource_arbiter.sv
// Runs a programmable sequence of sub-FSM phases, granting each active phase
// exclusive use of the shared counters, RAM port and chip drivers.
module seq_resource_arbiter
  import seq_resource_arbiter_pkg::*;
#(
  parameter int unsigned      N_PH         = 4,
  parameter int unsigned      CTRL_W       = 5,
  parameter int unsigned      DATA_W       = 12,
  parameter int unsigned      TO_W         = 16,
  parameter int unsigned      RPT_W        = 8,
  parameter logic [CTRL_W-1:0] IDLE_CTRL   = 5'b10000,
  parameter logic [N_PH-1:0]  ROW_ENA_MASK = DEF_ROW_ENA_MASK,
  parameter logic [N_PH-1:0]  COL_RST_MASK = DEF_COL_RST_MASK,
  parameter logic [N_PH-1:0]  RAM_RD_MASK  = DEF_RAM_RD_MASK,
  localparam int unsigned     PH_W         = (N_PH > 1) ? $clog2(N_PH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [N_PH-1:0]          i_phase_mask,
  input  logic [RPT_W-1:0]         i_repeat,
  input  logic [TO_W-1:0]          i_timeout,
  input  logic [N_PH-1:0]          i_end,
  input  logic [N_PH*CTRL_W-1:0]   i_col_control,
  input  logic [N_PH*CTRL_W-1:0]   i_row_control,
  input  logic [N_PH-1:0]          i_ram_wren,
  input  logic [N_PH-1:0]          i_ram_read,
  input  logic [N_PH*DATA_W-1:0]   i_ram_data,
  input  logic [N_PH*5-1:0]        i_drv,
  input  logic [N_PH-1:0]          i_row_rst,
  output logic [N_PH-1:0]          o_go,
  output logic [CTRL_W-1:0]        o_col_control,
  output logic [CTRL_W-1:0]        o_row_control,
  output logic                     o_ram_wren,
  output logic                     o_ram_read,
  output logic                     o_ram_ena,
  output logic                     o_ram_rsta,
  output logic [DATA_W-1:0]        o_ram_data,
  output logic [4:0]               o_drv,
  output logic                     o_row_rst,
  output logic                     o_chip_row_ena,
  output logic                     o_chip_col_rst,
  output logic [PH_W-1:0]          o_phase,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_done_pulse,
  output logic                     o_err,
  output logic                     o_aborted
);

  logic [1:0]      state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [N_PH-1:0] mask_q, mask_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            done_pulse_q, done_pulse_d;
  logic            aborted_q, aborted_d;

  logic [CTRL_W-1:0] col_arr  [N_PH];
  logic [CTRL_W-1:0] row_arr  [N_PH];
  logic [DATA_W-1:0] data_arr [N_PH];
  logic [4:0]        drv_arr  [N_PH];

  for (genvar k = 0; k < N_PH; k++) begin : g_unpack
    assign col_arr[k]  = i_col_control[k*CTRL_W +: CTRL_W];
    assign row_arr[k]  = i_row_control[k*CTRL_W +: CTRL_W];
    assign data_arr[k] = i_ram_data[k*DATA_W +: DATA_W];
    assign drv_arr[k]  = i_drv[k*5 +: 5];
  end

  logic [PH_W-1:0] nxt_idx, low_idx;
  logic            nxt_found, low_found;
  logic [N_PH-1:0] low_mask;
  logic [TO_W-1:0] wd_inc;

  // In IDLE the lowest bit comes from the live mask; on a repeat, from the latched one.
  assign low_mask = (state_q == StIdle) ? i_phase_mask : mask_q;
  assign wd_inc   = wd_q + TO_W'(1);

  seq_next_phase #(
    .N_PH (N_PH),
    .PH_W (PH_W)
  ) u_next_above (
    .mask  (mask_q),
    .start ((PH_W + 1)'(phase_q) + (PH_W + 1)'(1)),
    .idx   (nxt_idx),
    .found (nxt_found)
  );

  seq_next_phase #(
    .N_PH (N_PH),
    .PH_W (PH_W)
  ) u_next_lowest (
    .mask  (low_mask),
    .start ('0),
    .idx   (low_idx),
    .found (low_found)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    mask_d       = mask_q;
    rpt_d        = rpt_q;
    to_d         = to_q;
    wd_d         = wd_q;
    err_d        = err_q;
    done_pulse_d = 1'b0;
    aborted_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start && low_found) begin
          mask_d  = i_phase_mask;
          rpt_d   = i_repeat;
          to_d    = i_timeout;
          err_d   = 1'b0;
          wd_d    = '0;
          phase_d = low_idx;
          state_d = StRun;
        end
      end
      StRun: begin
        wd_d = wd_inc;
        if (i_abort) begin
          aborted_d = 1'b1;
          phase_d   = '0;
          state_d   = StIdle;
        end else if ((to_q != '0) && (wd_inc == to_q)) begin
          err_d   = 1'b1;
          phase_d = '0;
          state_d = StErr;
        end else if (i_end[phase_q]) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (i_abort) begin
          aborted_d = 1'b1;
          phase_d   = '0;
          state_d   = StIdle;
        end else if (nxt_found) begin
          phase_d = nxt_idx;
          wd_d    = '0;
          state_d = StRun;
        end else if (rpt_q != '0) begin
          rpt_d   = rpt_q - RPT_W'(1);
          phase_d = low_idx;
          wd_d    = '0;
          state_d = StRun;
        end else begin
          done_pulse_d = 1'b1;
          phase_d      = '0;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      mask_q       <= '0;
      rpt_q        <= '0;
      to_q         <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
      done_pulse_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else if (en) begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      mask_q       <= mask_d;
      rpt_q        <= rpt_d;
      to_q         <= to_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      done_pulse_q <= done_pulse_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    o_go           = '0;
    o_col_control  = IDLE_CTRL;
    o_row_control  = IDLE_CTRL;
    o_ram_wren     = 1'b0;
    o_ram_read     = 1'b0;
    o_ram_ena      = 1'b0;
    o_ram_rsta     = 1'b1;
    o_ram_data     = '0;
    o_drv          = '0;
    o_row_rst      = 1'b0;
    o_chip_row_ena = 1'b0;
    o_chip_col_rst = 1'b1;
    if (state_q == StRun) begin
      o_go[phase_q]  = 1'b1;
      o_col_control  = col_arr[phase_q];
      o_row_control  = row_arr[phase_q];
      o_ram_wren     = i_ram_wren[phase_q];
      o_ram_read     = i_ram_read[phase_q] | RAM_RD_MASK[phase_q];
      o_ram_ena      = 1'b1;
      o_ram_rsta     = 1'b0;
      o_ram_data     = data_arr[phase_q];
      o_drv          = drv_arr[phase_q];
      o_row_rst      = i_row_rst[phase_q];
      o_chip_row_ena = ROW_ENA_MASK[phase_q];
      o_chip_col_rst = COL_RST_MASK[phase_q];
    end
  end

  assign o_phase      = phase_q;
  assign o_busy       = (state_q == StRun) || (state_q == StGap);
  assign o_done       = (state_q == StIdle);
  assign o_done_pulse = done_pulse_q;
  assign o_err        = err_q;
  assign o_aborted    = aborted_q;

endmodule

// File: tb/tb_seq_resource_arbiter.sv
// Directed self-checking bench for seq_resource_arbiter.
module tb_seq_resource_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        i_start;
  logic        i_abort;
  logic [3:0]  i_phase_mask;
  logic [7:0]  i_repeat;
  logic [15:0] i_timeout;
  logic [3:0]  i_end;
  logic [19:0] i_col_control;
  logic [19:0] i_row_control;
  logic [3:0]  i_ram_wren;
  logic [3:0]  i_ram_read;
  logic [47:0] i_ram_data;
  logic [19:0] i_drv;
  logic [3:0]  i_row_rst;
  logic [3:0]  o_go;
  logic [4:0]  o_col_control;
  logic [4:0]  o_row_control;
  logic        o_ram_wren;
  logic        o_ram_read;
  logic        o_ram_ena;
  logic        o_ram_rsta;
  logic [11:0] o_ram_data;
  logic [4:0]  o_drv;
  logic        o_row_rst;
  logic        o_chip_row_ena;
  logic        o_chip_col_rst;
  logic [1:0]  o_phase;
  logic        o_busy;
  logic        o_done;
  logic        o_done_pulse;
  logic        o_err;
  logic        o_aborted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_resource_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_phase_mask   (i_phase_mask),
    .i_repeat       (i_repeat),
    .i_timeout      (i_timeout),
    .i_end          (i_end),
    .i_col_control  (i_col_control),
    .i_row_control  (i_row_control),
    .i_ram_wren     (i_ram_wren),
    .i_ram_read     (i_ram_read),
    .i_ram_data     (i_ram_data),
    .i_drv          (i_drv),
    .i_row_rst      (i_row_rst),
    .o_go           (o_go),
    .o_col_control  (o_col_control),
    .o_row_control  (o_row_control),
    .o_ram_wren     (o_ram_wren),
    .o_ram_read     (o_ram_read),
    .o_ram_ena      (o_ram_ena),
    .o_ram_rsta     (o_ram_rsta),
    .o_ram_data     (o_ram_data),
    .o_drv          (o_drv),
    .o_row_rst      (o_row_rst),
    .o_chip_row_ena (o_chip_row_ena),
    .o_chip_col_rst (o_chip_col_rst),
    .o_phase        (o_phase),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_done_pulse   (o_done_pulse),
    .o_err          (o_err),
    .o_aborted      (o_aborted)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_go"}, 32'(o_go), 32'h0);
    check_eq({tag, "_col"}, 32'(o_col_control), 32'h10);
    check_eq({tag, "_row"}, 32'(o_row_control), 32'h10);
    check_eq({tag, "_ram_ena"}, 32'(o_ram_ena), 32'h0);
    check_eq({tag, "_ram_rsta"}, 32'(o_ram_rsta), 32'h1);
    check_eq({tag, "_col_rst"}, 32'(o_chip_col_rst), 32'h1);
    check_eq({tag, "_row_ena"}, 32'(o_chip_row_ena), 32'h0);
    check_eq({tag, "_wren"}, 32'(o_ram_wren), 32'h0);
    check_eq({tag, "_data"}, 32'(o_ram_data), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    en            = 1'b1;
    i_start       = 1'b0;
    i_abort       = 1'b0;
    i_phase_mask  = 4'b0000;
    i_repeat      = 8'd0;
    i_timeout     = 16'd0;
    i_end         = 4'b0000;
    i_col_control = {5'd4, 5'd3, 5'd2, 5'd1};
    i_row_control = {5'd8, 5'd7, 5'd6, 5'd5};
    i_ram_wren    = 4'b0101;
    i_ram_read    = 4'b0000;
    i_ram_data    = {12'h000, 12'h000, 12'h123, 12'hABC};
    i_drv         = {5'h15, 5'h15, 5'h0A, 5'h15};
    i_row_rst     = 4'b0000;

    tick();
    tick();
    check_idle_outputs("reset");
    check_eq("reset_done", 32'(o_done), 32'h1);
    check_eq("reset_busy", 32'(o_busy), 32'h0);
    check_eq("reset_err", 32'(o_err), 32'h0);
    check_eq("reset_phase", 32'(o_phase), 32'h0);
    check_eq("reset_done_pulse", 32'(o_done_pulse), 32'h0);
    check_eq("reset_aborted", 32'(o_aborted), 32'h0);
    rst = 1'b0;
    tick();

    // Zero mask is ignored.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("zero_mask_done", 32'(o_done), 32'h1);
    check_eq("zero_mask_go", 32'(o_go), 32'h0);
    tick();
    check_eq("zero_mask_pulse", 32'(o_done_pulse), 32'h0);

    // Two-phase sequence: phase 0 for 4 cycles, phase 1 for 6.
    i_phase_mask = 4'b0011;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_ph0_go", 32'(o_go), 32'h1);
      if (i == 0) begin
        check_eq("seq_ph0_busy", 32'(o_busy), 32'h1);
        check_eq("seq_ph0_col", 32'(o_col_control), 32'd1);
        check_eq("seq_ph0_row", 32'(o_row_control), 32'd5);
        check_eq("seq_ph0_wren", 32'(o_ram_wren), 32'h1);
        check_eq("seq_ph0_data", 32'(o_ram_data), 32'hABC);
        check_eq("seq_ph0_ram_ena", 32'(o_ram_ena), 32'h1);
        check_eq("seq_ph0_ram_rsta", 32'(o_ram_rsta), 32'h0);
        check_eq("seq_ph0_row_ena", 32'(o_chip_row_ena), 32'h1);
        check_eq("seq_ph0_col_rst", 32'(o_chip_col_rst), 32'h0);
      end
      // Another phase's end flag must not end phase 0.
      i_end = (i == 1) ? 4'b0010 : ((i == 3) ? 4'b0001 : 4'b0000);
      if (i == 2) i_start = 1'b1;
      tick();
      i_start = 1'b0;
    end
    i_end = 4'b0000;
    check_eq("seq_gap1_go", 32'(o_go), 32'h0);
    check_eq("seq_gap1_busy", 32'(o_busy), 32'h1);
    check_eq("seq_gap1_col", 32'(o_col_control), 32'h10);
    check_eq("seq_gap1_wren", 32'(o_ram_wren), 32'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check_eq("seq_ph1_go", 32'(o_go), 32'h2);
      if (i == 0) begin
        check_eq("seq_ph1_phase", 32'(o_phase), 32'h1);
        check_eq("seq_ph1_wren", 32'(o_ram_wren), 32'h0);
        check_eq("seq_ph1_data", 32'(o_ram_data), 32'h123);
        check_eq("seq_ph1_col", 32'(o_col_control), 32'd2);
        check_eq("seq_ph1_row", 32'(o_row_control), 32'd6);
        check_eq("seq_ph1_drv", 32'(o_drv), 32'h0A);
        check_eq("seq_ph1_ram_read", 32'(o_ram_read), 32'h0);
      end
      if (i == 5) i_end = 4'b0010;
      tick();
    end
    i_end = 4'b0000;
    check_eq("seq_gap2_go", 32'(o_go), 32'h0);
    check_eq("seq_gap2_pulse", 32'(o_done_pulse), 32'h0);
    tick();
    check_eq("seq_end_done", 32'(o_done), 32'h1);
    check_eq("seq_end_pulse", 32'(o_done_pulse), 32'h1);
    check_eq("seq_end_busy", 32'(o_busy), 32'h0);
    tick();
    check_eq("seq_end_pulse_off", 32'(o_done_pulse), 32'h0);

    // Single phase 2 with repeat 2: three runs, one done pulse.
    i_phase_mask = 4'b0100;
    i_repeat     = 8'd2;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 2; j++) begin
        check_eq("rpt_go", 32'(o_go), 32'h4);
        check_eq("rpt_ram_read", 32'(o_ram_read), 32'h1);
        check_eq("rpt_col_rst", 32'(o_chip_col_rst), 32'h1);
        check_eq("rpt_row_ena", 32'(o_chip_row_ena), 32'h0);
        i_end = (j == 1) ? 4'b0100 : 4'b0000;
        tick();
      end
      i_end = 4'b0000;
      check_eq("rpt_gap_go", 32'(o_go), 32'h0);
      check_eq("rpt_gap_busy", 32'(o_busy), 32'h1);
      check_eq("rpt_gap_pulse", 32'(o_done_pulse), 32'h0);
      tick();
    end
    check_eq("rpt_done_pulse", 32'(o_done_pulse), 32'h1);
    check_eq("rpt_done", 32'(o_done), 32'h1);
    i_repeat = 8'd0;
    tick();
    check_eq("rpt_done_pulse_off", 32'(o_done_pulse), 32'h0);

    // Watchdog: phase 3, limit 10; i_end on the expiring cycle loses to the error.
    i_phase_mask = 4'b1000;
    i_timeout    = 16'd10;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("wd_run_go", 32'(o_go), 32'h8);
      if (i == 9) i_end = 4'b1000;
      tick();
    end
    i_end = 4'b0000;
    check_eq("wd_err_flag", 32'(o_err), 32'h1);
    check_eq("wd_err_done", 32'(o_done), 32'h0);
    check_eq("wd_err_busy", 32'(o_busy), 32'h0);
    check_idle_outputs("wd_err");
    tick();
    check_eq("wd_idle_done", 32'(o_done), 32'h1);
    check_eq("wd_idle_err", 32'(o_err), 32'h1);
    check_eq("wd_no_pulse", 32'(o_done_pulse), 32'h0);
    tick();
    check_eq("wd_sticky_err", 32'(o_err), 32'h1);
    i_phase_mask = 4'b0001;
    i_timeout    = 16'd0;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("wd_restart_err", 32'(o_err), 32'h0);
    check_eq("wd_restart_go", 32'(o_go), 32'h1);
    i_end = 4'b0001;
    tick();
    i_end = 4'b0000;
    tick();
    check_eq("wd_restart_done", 32'(o_done_pulse), 32'h1);
    tick();

    // Abort in the second RUN cycle of phase 1.
    i_phase_mask = 4'b0011;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    i_end   = 4'b0001;
    tick();
    i_end = 4'b0000;
    tick();
    check_eq("abort_ph1_go1", 32'(o_go), 32'h2);
    tick();
    check_eq("abort_ph1_go2", 32'(o_go), 32'h2);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check_eq("abort_pulse", 32'(o_aborted), 32'h1);
    check_eq("abort_no_done_pulse", 32'(o_done_pulse), 32'h0);
    check_eq("abort_done", 32'(o_done), 32'h1);
    check_eq("abort_col", 32'(o_col_control), 32'h10);
    check_eq("abort_go", 32'(o_go), 32'h0);
    tick();
    check_eq("abort_pulse_off", 32'(o_aborted), 32'h0);
    check_eq("abort_no_done_later", 32'(o_done_pulse), 32'h0);

    // Clock enable freezes state and watchdog; the i_end pulse is missed.
    i_phase_mask = 4'b0010;
    i_timeout    = 16'd4;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_end = (i == 2) ? 4'b0010 : 4'b0000;
      tick();
      check_eq("en_freeze_go", 32'(o_go), 32'h2);
    end
    i_end = 4'b0000;
    en    = 1'b1;
    tick();
    check_eq("en_resume_go1", 32'(o_go), 32'h2);
    tick();
    check_eq("en_resume_go2", 32'(o_go), 32'h2);
    tick();
    check_eq("en_resume_err", 32'(o_err), 32'h1);
    check_eq("en_resume_state", 32'(o_done), 32'h0);
    tick();

    // Asynchronous reset in the middle of RUN.
    i_phase_mask = 4'b0001;
    i_timeout    = 16'd0;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    check_eq("arst_pre_go", 32'(o_go), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("arst");
    check_eq("arst_done", 32'(o_done), 32'h1);
    check_eq("arst_busy", 32'(o_busy), 32'h0);
    check_eq("arst_err", 32'(o_err), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("arst_after_done", 32'(o_done), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_resource_arbiter.md
Name: seq_resource_arbiter

Overview:
- Parametrised successor to the sensor top-level controller.
- Runs an arbitrary, programmable sequence of sub-FSM phases (pixel reset, scan, process, config, future phases) in ascending index order.
- Grants each active phase exclusive ownership of the shared row/col counters, block RAM port and chip drivers.
- Adds a repeat count, a per-phase watchdog timeout and an abort; the original fixed 3-bit mode decode had none of these.

Parameters:
- N_PH, 4, number of client phases (index 0 runs first).
- CTRL_W, 5, width of each col/row counter control word.
- DATA_W, 12, RAM data width.
- TO_W, 16, watchdog counter width.
- RPT_W, 8, repeat counter width.
- IDLE_CTRL, 5'b10000, col/row control value driven while no phase owns the bus.
- ROW_ENA_MASK, 4'b1011, per-phase value of o_chip_row_ena.
- COL_RST_MASK, 4'b0100, per-phase value of o_chip_col_rst.
- RAM_RD_MASK, 4'b0100, per-phase forced RAM read.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  clock enable for all state, counter and latch updates
- i_start  in  1  start request, sampled in IDLE only
- i_abort  in  1  abort the running sequence
- i_phase_mask  in  N_PH  phases to run; latched at start
- i_repeat  in  RPT_W  extra sequence passes (0 = single pass); latched at start
- i_timeout  in  TO_W  per-phase cycle limit (0 = watchdog disabled); latched at start
- i_end  in  N_PH  per-phase completion flag from each sub-FSM
- i_col_control  in  N_PH*CTRL_W  per-phase col counter control, phase k at [k*CTRL_W +: CTRL_W]
- i_row_control  in  N_PH*CTRL_W  per-phase row counter control, same packing
- i_ram_wren  in  N_PH  per-phase RAM write enable
- i_ram_read  in  N_PH  per-phase RAM read request
- i_ram_data  in  N_PH*DATA_W  per-phase RAM write data
- i_drv  in  N_PH*5  per-phase {row_reg_data, row_reg_write, col_reg_data, col_reg_write, key_wren}
- i_row_rst  in  N_PH  per-phase row reset
- o_go  out  N_PH  one-hot ownership grant
- o_col_control  out  CTRL_W  muxed col control
- o_row_control  out  CTRL_W  muxed row control
- o_ram_wren  out  1  muxed RAM write enable
- o_ram_read  out  1  muxed RAM read
- o_ram_ena  out  1  RAM port enable
- o_ram_rsta  out  1  RAM reset
- o_ram_data  out  DATA_W  muxed RAM write data
- o_drv  out  5  muxed driver bundle
- o_row_rst  out  1  muxed row reset
- o_chip_row_ena  out  1  chip row enable
- o_chip_col_rst  out  1  chip column reset
- o_phase  out  clog2(N_PH)  index of the current phase
- o_busy  out  1  high in RUN or GAP
- o_done  out  1  level, high in IDLE
- o_done_pulse  out  1  one-cycle pulse on normal completion
- o_err  out  1  sticky watchdog error
- o_aborted  out  1  one-cycle pulse on abort

Behaviour:
- Reset values:
  - state IDLE; o_go=0; o_phase=0; o_busy=0; o_done=1.
  - o_done_pulse=0; o_err=0; o_aborted=0.
  - o_col_control=o_row_control=IDLE_CTRL.
  - o_chip_row_ena=0; o_chip_col_rst=1; o_ram_rsta=1; o_ram_ena=0.
  - All muxed strobes and data are 0.
- All registered updates happen only when en=1. Outputs are Moore, decoded from the registered state and phase.
- States: IDLE, RUN, GAP, ERR.
- IDLE:
  - i_start=1 with a nonzero mask: latch mask, repeat and timeout; clear o_err; go to RUN with phase = lowest set mask bit.
  - A zero mask is ignored (stay IDLE, no pulse).
- RUN:
  - o_go[phase]=1 and all muxed outputs select that phase.
  - o_chip_row_ena, o_chip_col_rst and the forced RAM read come from the mask parameters at bit [phase].
  - o_ram_ena=1; o_ram_rsta=0.
  - Non-owner inputs are ignored, never OR-merged.
  - The watchdog increments every cycle in RUN and clears on each RUN entry.
  - i_end[phase]=1 → GAP. i_end of other phases is ignored.
- GAP: exactly one cycle; o_go=0; muxed strobes 0; control=IDLE_CTRL. The next phase is then chosen:
  - Next higher set mask bit → RUN with that phase.
  - No higher bit and repeat count ≠ 0 → decrement the count, RUN with the lowest set bit.
  - Otherwise → IDLE and pulse o_done_pulse on the cycle of the IDLE entry.
- Watchdog: with a nonzero limit, the counter reaching the limit in RUN → ERR with o_err=1. Check order per cycle is i_abort, then watchdog, then i_end.
- ERR: drives the IDLE outputs except o_done=0. The next cycle returns to IDLE; o_err stays set until the next accepted start or rst.
- Abort: i_abort in RUN or GAP → IDLE next cycle, o_aborted pulse, no o_done_pulse.
- Simultaneous i_end and watchdog expiry: the error wins.
- i_start while busy is ignored.
- Asynchronous rst mid-sequence returns to the reset values immediately.
- Single-phase mask with repeat=R: that phase runs R+1 times, separated by GAP cycles.

Decomposition:
- Shared package holds:
  - state encodings;
  - the driver-bundle bit positions (ROW_DATA=4 .. KEY_WREN=0);
  - the default mask constants for the sensor phases: RESET=0, SCAN=1, PROCESS=2, CONF=3.
- Sub-module: seq_next_phase, a combinational priority search returning the next set mask bit above a given index, plus a found flag; instantiated twice, once for "above phase" and once for "lowest".

Test Plan:
- Mask 4'b0011, repeat 0, timeout 0, start; i_end[0] after 3 cycles, then i_end[1] after 5 → o_go 0001 ×4, one GAP cycle, 0010 ×6, one GAP cycle, then IDLE with o_done_pulse=1 for one cycle.
- Mask 4'b0100, repeat 2 → phase 2 runs 3 times, o_ram_read=1 and o_chip_col_rst=1 throughout, a single done pulse.
- Mask 4'b1000, timeout 10, i_end never asserted → ERR after 10 RUN cycles, o_err=1 sticky; the next start clears it.
- Mask 4'b0011, i_abort in the 2nd RUN cycle of phase 1 → IDLE, o_aborted pulse, no done pulse, o_col_control=5'b10000.
- Phase 1 running with i_ram_wren=4'b0101 and i_ram_data[0]=12'hABC → o_ram_wren=0; o_ram_data shows phase 1's data only.
- rst asserted during RUN; en=0 held for 5 cycles while i_end is pulsed → immediate reset values; with en low, state and watchdog are frozen and the i_end pulse is missed.
